// File: rtl/counter_ctrl_if.sv
// Control and display bundle for counter_ctrl: pulse/level controls in,
// BCD count, multiplexed 7-segment drive and status out.
interface counter_ctrl_if;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic       up_down;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] an;
    logic [6:0] seg;
    logic       running;
    logic       wrap;

    modport master (
        output tick_in, start_stop, clear, up_down,
        input  tens, ones, an, seg, running, wrap
    );

    modport slave (
        input  tick_in, start_stop, clear, up_down,
        output tens, ones, an, seg, running, wrap
    );
endinterface

// File: rtl/counter_ctrl.sv
// Two-digit BCD up/down counter with IDLE/RUN/PAUSE control, tick-driven step
// prescaler and a two-digit multiplexed 7-segment display scanner.
module counter_ctrl #(
    parameter int unsigned TICKS_PER_STEP = 100,
    parameter int unsigned SCAN_TICKS     = 1
) (
    input  logic          clock_in,
    input  logic          reset,
    counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [15:0] STEP_LAST = 16'(TICKS_PER_STEP - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_TICKS - 1);

    state_t      state, state_next;
    logic [15:0] step_cnt, scan_cnt;
    logic [3:0]  tens_q, ones_q;
    logic [3:0]  tens_step, ones_step, digit;
    logic [1:0]  an_q;
    logic        wrap_q, wrap_step;
    logic        step_tick, step_en;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Prescaler and step qualify on the current state, not the next one.
    assign step_tick = (state == RUN) && bus.tick_in;
    assign step_en   = step_tick && (step_cnt == STEP_LAST);

    always_comb begin
        tens_step = tens_q;
        ones_step = ones_q;
        wrap_step = 1'b0;
        if (bus.up_down) begin
            if (ones_q >= 4'd9) begin
                ones_step = 4'd0;
                if (tens_q >= 4'd9) begin
                    tens_step = 4'd0;
                    wrap_step = 1'b1;
                end else begin
                    tens_step = tens_q + 4'd1;
                end
            end else begin
                ones_step = ones_q + 4'd1;
            end
        end else begin
            if (ones_q == 4'd0) begin
                ones_step = 4'd9;
                if (tens_q == 4'd0) begin
                    tens_step = 4'd9;
                    wrap_step = 1'b1;
                end else begin
                    tens_step = tens_q - 4'd1;
                end
            end else begin
                ones_step = ones_q - 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            scan_cnt <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            an_q     <= 2'b10;
            wrap_q   <= 1'b0;
        end else begin
            state  <= state_next;
            wrap_q <= 1'b0;

            if (bus.clear) begin
                step_cnt <= '0;
                tens_q   <= '0;
                ones_q   <= '0;
            end else if (step_en) begin
                step_cnt <= '0;
                tens_q   <= tens_step;
                ones_q   <= ones_step;
                wrap_q   <= wrap_step;
            end else if (step_tick) begin
                step_cnt <= step_cnt + 16'd1;
            end

            // The display scan free-runs on ticks and ignores clear.
            if (bus.tick_in) begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt <= '0;
                    an_q     <= ~an_q;
                end else begin
                    scan_cnt <= scan_cnt + 16'd1;
                end
            end
        end
    end

    assign digit = (an_q == 2'b01) ? tens_q : ones_q;

    always_comb begin
        bus.seg = 7'b1111111;
        case (digit)
            4'd0:    bus.seg = 7'b1000000;
            4'd1:    bus.seg = 7'b1111001;
            4'd2:    bus.seg = 7'b0100100;
            4'd3:    bus.seg = 7'b0110000;
            4'd4:    bus.seg = 7'b0011001;
            4'd5:    bus.seg = 7'b0010010;
            4'd6:    bus.seg = 7'b0000010;
            4'd7:    bus.seg = 7'b1111000;
            4'd8:    bus.seg = 7'b0000000;
            4'd9:    bus.seg = 7'b0010000;
            default: bus.seg = 7'b1111111;
        endcase
    end

    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.an      = an_q;
    assign bus.wrap    = wrap_q;
    assign bus.running = (state == RUN);

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter TICKS_PER_STEP, default 100, meaning tick_in pulses per count step (legal range 1..65535).
REQ-002 The block SHALL have parameter SCAN_TICKS, default 1, meaning tick_in pulses per display digit swap (legal range 1..65535).
REQ-003 clock_in  input  1  the single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_in  input  1  single-cycle enable pulse from the clock divider; never used as a clock.
REQ-006 start_stop  input  1  single-cycle pulse, already debounced and synchronised; toggles run/pause.
REQ-007 clear  input  1  single-cycle pulse, already debounced and synchronised; returns the block to IDLE at 00.
REQ-008 up_down  input  1  level; 1 = count up, 0 = count down; sampled at each step.
REQ-009 tens  output  4  BCD tens digit, 0..9, registered.
REQ-010 ones  output  4  BCD ones digit, 0..9, registered.
REQ-011 an  output  2  active-low digit enables; 2'b10 = ones shown, 2'b01 = tens shown, registered.
REQ-012 seg  output  7  active-low segments {g,f,e,d,c,b,a} of the digit selected by an.
REQ-013 running  output  1  high exactly while the FSM is in RUN.
REQ-014 wrap  output  1  one-cycle pulse on a 99->00 or 00->99 step.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-016 Transitions SHALL be: IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN; any state --clear--> IDLE.
REQ-017 When clear and start_stop are high in the same cycle, clear SHALL win and the next state SHALL be IDLE.
REQ-018 Entering IDLE SHALL set tens=0, ones=0 and the step prescaler to 0 on the same edge.
REQ-019 The step prescaler SHALL advance only on cycles where the current state is RUN and tick_in=1, and SHALL hold in PAUSE.
REQ-020 When the prescaler equals TICKS_PER_STEP-1 and it advances, it SHALL return to 0 and the count SHALL step on that same edge (outputs change one cycle after the qualifying tick_in sample).
REQ-021 Step and prescaler evaluation SHALL use the current state: a tick coinciding with RUN->PAUSE still counts; a tick coinciding with IDLE->RUN or PAUSE->RUN is ignored.
REQ-022 Up step SHALL be BCD: ones 9->0 with tens+1; 99->00 with wrap=1 for one cycle.
REQ-023 Down step SHALL be BCD: ones 0->9 with tens-1; 00->99 with wrap=1 for one cycle.
REQ-024 A clear coinciding with a step-qualifying tick SHALL yield 00 with wrap=0.
REQ-025 The scan counter SHALL advance on every tick_in in all states; on reaching SCAN_TICKS-1 it SHALL return to 0 and an SHALL toggle between 2'b10 and 2'b01.
REQ-026 seg SHALL be a combinational decode of the registered selected digit (ones when an=2'b10, tens when an=2'b01); 0 = 7'b1000000, 1 = 7'b1111001, ..., 9 = 7'b0010000.
REQ-027 clear SHALL NOT affect the scan counter or an.
REQ-028 tens and ones SHALL never hold values above 9.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL enter IDLE with tens=0, ones=0, an=2'b10, running=0, wrap=0 and both internal counters at 0, so seg=7'b1000000.
REQ-030 reset SHALL take priority over clear, start_stop and tick_in, including mid-step and mid-scan.

Verification (TICKS_PER_STEP=4, SCAN_TICKS=2 unless stated)
REQ-031 Reset, then start_stop, then 8 tick_in pulses with up_down=1 -> count 00->01->02, running=1 from the cycle after start_stop.
REQ-032 Preload to 99 in RUN with up_down=1, then 4 ticks -> 00 with wrap high for exactly 1 cycle; repeat at 00 with up_down=0 -> 99 with wrap pulse.
REQ-033 RUN at 05 with prescaler at 2, start_stop, then 10 ticks, then start_stop and 2 ticks -> holds 05 during PAUSE, then 06 after the 2nd resumed tick.
REQ-034 clear and start_stop in the same cycle from RUN at 37 -> next cycle IDLE, 00, running=0, wrap=0.
REQ-035 Six ticks in IDLE -> an sequence 10,01,01,10,10,01 sampled after each tick; seg always 7'b1000000 with count 00.
REQ-036 reset asserted with a step-qualifying tick in RUN at 42 -> next cycle 00, IDLE, an=2'b10, wrap=0.
